// File: rtl/conv_loop_controller.sv
// Loop sequencer for a convolution layer: walks out_y, out_x, out_ch, k_y, k_x, in_ch
// over jointly-transferred feature/weight beats and flags each completed output.
module conv_loop_controller #(
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 16,
  localparam int X_W   = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
  localparam int Y_W   = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int ICH_W = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1,
  localparam int OCH_W = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             start,
  input  logic             conv_kernel_mode,
  input  logic             conv_stride_mode,
  input  logic             a_valid,
  input  logic             b_valid,
  output logic             a_ready,
  output logic             b_ready,
  output logic [1:0]       k_x,
  output logic [1:0]       k_y,
  output logic [ICH_W-1:0] in_ch,
  output logic             mac_valid,
  output logic             mac_first,
  output logic             mac_last,
  output logic             output_valid,
  output logic [X_W-1:0]   output_x,
  output logic [Y_W-1:0]   output_y,
  output logic [OCH_W-1:0] output_ch,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Output grid sizes for each kernel/stride combination (valid convolution, no padding)
  localparam int OW_K3S1 = (FEATURE_MAP_WIDTH  - 3) / 1 + 1;
  localparam int OW_K3S2 = (FEATURE_MAP_WIDTH  - 3) / 2 + 1;
  localparam int OW_K1S1 = (FEATURE_MAP_WIDTH  - 1) / 1 + 1;
  localparam int OW_K1S2 = (FEATURE_MAP_WIDTH  - 1) / 2 + 1;
  localparam int OH_K3S1 = (FEATURE_MAP_HEIGHT - 3) / 1 + 1;
  localparam int OH_K3S2 = (FEATURE_MAP_HEIGHT - 3) / 2 + 1;
  localparam int OH_K1S1 = (FEATURE_MAP_HEIGHT - 1) / 1 + 1;
  localparam int OH_K1S2 = (FEATURE_MAP_HEIGHT - 1) / 2 + 1;

  localparam logic [ICH_W-1:0] ICH_MAX = ICH_W'(INPUT_NB_CHANNELS - 1);
  localparam logic [OCH_W-1:0] OCH_MAX = OCH_W'(OUTPUT_NB_CHANNELS - 1);

  state_t state_q, state_d;
  logic   kernel_q, kernel_d;
  logic   stride_q, stride_d;

  logic [X_W-1:0]   cnt_out_x_q, cnt_out_x_d;
  logic [Y_W-1:0]   cnt_out_y_q, cnt_out_y_d;
  logic [OCH_W-1:0] cnt_out_ch_q, cnt_out_ch_d;
  logic [1:0]       cnt_k_y_q, cnt_k_y_d;
  logic [1:0]       cnt_k_x_q, cnt_k_x_d;
  logic [ICH_W-1:0] cnt_in_ch_q, cnt_in_ch_d;

  logic             output_valid_q, output_valid_d;
  logic [X_W-1:0]   output_x_q, output_x_d;
  logic [Y_W-1:0]   output_y_q, output_y_d;
  logic [OCH_W-1:0] output_ch_q, output_ch_d;

  logic [1:0]     k_max;
  logic [X_W-1:0] x_max;
  logic [Y_W-1:0] y_max;
  logic           transfer;
  logic           inner_last;
  logic           final_beat;

  // Loop limits follow the modes latched at start, never the live inputs
  always_comb begin
    k_max = kernel_q ? 2'd0 : 2'd2;
    x_max = X_W'(OW_K3S1 - 1);
    y_max = Y_W'(OH_K3S1 - 1);
    case ({kernel_q, stride_q})
      2'b00: begin
        x_max = X_W'(OW_K3S1 - 1);
        y_max = Y_W'(OH_K3S1 - 1);
      end
      2'b01: begin
        x_max = X_W'(OW_K3S2 - 1);
        y_max = Y_W'(OH_K3S2 - 1);
      end
      2'b10: begin
        x_max = X_W'(OW_K1S1 - 1);
        y_max = Y_W'(OH_K1S1 - 1);
      end
      default: begin
        x_max = X_W'(OW_K1S2 - 1);
        y_max = Y_W'(OH_K1S2 - 1);
      end
    endcase
  end

  assign transfer   = (state_q == RUN) && a_valid && b_valid;
  assign inner_last = (cnt_in_ch_q == ICH_MAX) && (cnt_k_x_q == k_max) && (cnt_k_y_q == k_max);
  assign final_beat = inner_last && (cnt_out_ch_q == OCH_MAX) &&
                      (cnt_out_x_q == x_max) && (cnt_out_y_q == y_max);

  always_comb begin
    state_d        = state_q;
    kernel_d       = kernel_q;
    stride_d       = stride_q;
    cnt_out_x_d    = cnt_out_x_q;
    cnt_out_y_d    = cnt_out_y_q;
    cnt_out_ch_d   = cnt_out_ch_q;
    cnt_k_y_d      = cnt_k_y_q;
    cnt_k_x_d      = cnt_k_x_q;
    cnt_in_ch_d    = cnt_in_ch_q;
    output_valid_d = 1'b0;
    output_x_d     = output_x_q;
    output_y_d     = output_y_q;
    output_ch_d    = output_ch_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          kernel_d     = conv_kernel_mode;
          stride_d     = conv_stride_mode;
          cnt_out_x_d  = '0;
          cnt_out_y_d  = '0;
          cnt_out_ch_d = '0;
          cnt_k_y_d    = '0;
          cnt_k_x_d    = '0;
          cnt_in_ch_d  = '0;
        end
      end

      RUN: begin
        if (transfer) begin
          // Odometer carry chain, innermost first; every counter wraps to 0 at its limit
          if (cnt_in_ch_q == ICH_MAX) begin
            cnt_in_ch_d = '0;
            if (cnt_k_x_q == k_max) begin
              cnt_k_x_d = '0;
              if (cnt_k_y_q == k_max) begin
                cnt_k_y_d = '0;
                if (cnt_out_ch_q == OCH_MAX) begin
                  cnt_out_ch_d = '0;
                  if (cnt_out_x_q == x_max) begin
                    cnt_out_x_d = '0;
                    if (cnt_out_y_q == y_max) begin
                      cnt_out_y_d = '0;
                    end else begin
                      cnt_out_y_d = cnt_out_y_q + 1'b1;
                    end
                  end else begin
                    cnt_out_x_d = cnt_out_x_q + 1'b1;
                  end
                end else begin
                  cnt_out_ch_d = cnt_out_ch_q + 1'b1;
                end
              end else begin
                cnt_k_y_d = cnt_k_y_q + 2'd1;
              end
            end else begin
              cnt_k_x_d = cnt_k_x_q + 2'd1;
            end
          end else begin
            cnt_in_ch_d = cnt_in_ch_q + 1'b1;
          end

          if (inner_last) begin
            output_valid_d = 1'b1;
            output_x_d     = cnt_out_x_q;
            output_y_d     = cnt_out_y_q;
            output_ch_d    = cnt_out_ch_q;
          end

          if (final_beat) begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q        <= IDLE;
      kernel_q       <= 1'b0;
      stride_q       <= 1'b0;
      cnt_out_x_q    <= '0;
      cnt_out_y_q    <= '0;
      cnt_out_ch_q   <= '0;
      cnt_k_y_q      <= '0;
      cnt_k_x_q      <= '0;
      cnt_in_ch_q    <= '0;
      output_valid_q <= 1'b0;
      output_x_q     <= '0;
      output_y_q     <= '0;
      output_ch_q    <= '0;
    end else begin
      state_q        <= state_d;
      kernel_q       <= kernel_d;
      stride_q       <= stride_d;
      cnt_out_x_q    <= cnt_out_x_d;
      cnt_out_y_q    <= cnt_out_y_d;
      cnt_out_ch_q   <= cnt_out_ch_d;
      cnt_k_y_q      <= cnt_k_y_d;
      cnt_k_x_q      <= cnt_k_x_d;
      cnt_in_ch_q    <= cnt_in_ch_d;
      output_valid_q <= output_valid_d;
      output_x_q     <= output_x_d;
      output_y_q     <= output_y_d;
      output_ch_q    <= output_ch_d;
    end
  end

  // Handshake and MAC strobes are decoded from registered state so reset clears them at once
  assign a_ready      = (state_q == RUN) && b_valid;
  assign b_ready      = (state_q == RUN) && a_valid;
  assign mac_valid    = transfer;
  assign mac_first    = transfer && (cnt_k_y_q == 2'd0) && (cnt_k_x_q == 2'd0) && (cnt_in_ch_q == '0);
  assign mac_last     = transfer && inner_last;
  assign k_x          = cnt_k_x_q;
  assign k_y          = cnt_k_y_q;
  assign in_ch        = cnt_in_ch_q;
  assign output_valid = output_valid_q;
  assign output_x     = output_x_q;
  assign output_y     = output_y_q;
  assign output_ch    = output_ch_q;
  assign running      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_loop_controller.sv
// Self-checking bench for conv_loop_controller: a transfer-count model predicts every
// output each cycle, and directed layers pin counts, first/last coordinates and reset.
module tb_conv_loop_controller;

   localparam int W   = 8;
   localparam int H   = 8;
   localparam int IN  = 2;
   localparam int OUT = 2;
   localparam int BUDGET = 10000;

   logic       clk;
   logic       arst_n_in;
   logic       start;
   logic       conv_kernel_mode;
   logic       conv_stride_mode;
   logic       a_valid;
   logic       b_valid;
   logic       a_ready;
   logic       b_ready;
   logic [1:0] k_x;
   logic [1:0] k_y;
   logic [0:0] in_ch;
   logic       mac_valid;
   logic       mac_first;
   logic       mac_last;
   logic       output_valid;
   logic [2:0] output_x;
   logic [2:0] output_y;
   logic [0:0] output_ch;
   logic       running;

   int checks = 0;
   int errors = 0;

   // Model state: phase flags plus a linear transfer count within the layer
   bit m_run = 0;
   bit m_flush = 0;
   bit m_km = 0;
   bit m_sm = 0;
   bit m_ov = 0;
   int n = 0;
   int m_ox = 0;
   int m_oy = 0;
   int m_och = 0;

   // Per-layer statistics observed on the DUT
   int cyc_count = 0;
   int layer_ov = 0;
   int layer_xfer = 0;
   int first_ov_xfer = -1;
   int first_ov_cyc = -1;
   int first_xfer_cyc = -1;
   int last_ox = -1;
   int last_oy = -1;
   int last_och = -1;
   int kmax_seen = 0;

   conv_loop_controller #(
      .FEATURE_MAP_WIDTH (W),
      .FEATURE_MAP_HEIGHT(H),
      .INPUT_NB_CHANNELS (IN),
      .OUTPUT_NB_CHANNELS(OUT)
   ) dut (
      .clk             (clk),
      .arst_n_in       (arst_n_in),
      .start           (start),
      .conv_kernel_mode(conv_kernel_mode),
      .conv_stride_mode(conv_stride_mode),
      .a_valid         (a_valid),
      .b_valid         (b_valid),
      .a_ready         (a_ready),
      .b_ready         (b_ready),
      .k_x             (k_x),
      .k_y             (k_y),
      .in_ch           (in_ch),
      .mac_valid       (mac_valid),
      .mac_first       (mac_first),
      .mac_last        (mac_last),
      .output_valid    (output_valid),
      .output_x        (output_x),
      .output_y        (output_y),
      .output_ch       (output_ch),
      .running         (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   function automatic int kOf(input bit km);
      return km ? 1 : 3;
   endfunction

   function automatic int sOf(input bit sm);
      return sm ? 2 : 1;
   endfunction

   // Compare every cycle on the falling edge, then advance the model to the next rising edge
   always @(negedge clk) begin
      int kk;
      int ow;
      int oh;
      int B;
      int T;
      int nn;
      int r;
      int o;
      bit xfer;
      cyc_count++;
      if (!arst_n_in) begin
         checkOutput("rst_running", int'(running), 0);
         checkOutput("rst_a_ready", int'(a_ready), 0);
         checkOutput("rst_b_ready", int'(b_ready), 0);
         checkOutput("rst_mac_valid", int'(mac_valid), 0);
         checkOutput("rst_mac_first", int'(mac_first), 0);
         checkOutput("rst_mac_last", int'(mac_last), 0);
         checkOutput("rst_output_valid", int'(output_valid), 0);
         checkOutput("rst_indices", int'({k_x, k_y, in_ch}), 0);
         checkOutput("rst_coords", int'({output_x, output_y, output_ch}), 0);
         m_run = 0;
         m_flush = 0;
         m_ov = 0;
         n = 0;
         m_ox = 0;
         m_oy = 0;
         m_och = 0;
      end else begin
         kk = kOf(m_km);
         ow = (W - kk) / sOf(m_sm) + 1;
         oh = (H - kk) / sOf(m_sm) + 1;
         B = kk * kk * IN;
         T = ow * oh * OUT * B;
         nn = n % T;
         r = nn % B;
         o = nn / B;
         xfer = m_run && a_valid && b_valid;

         checkOutput("running", int'(running), int'(m_run || m_flush));
         checkOutput("a_ready", int'(a_ready), int'(m_run && b_valid));
         checkOutput("b_ready", int'(b_ready), int'(m_run && a_valid));
         checkOutput("mac_valid", int'(mac_valid), int'(xfer));
         checkOutput("mac_first", int'(mac_first), int'(xfer && r == 0));
         checkOutput("mac_last", int'(mac_last), int'(xfer && r == B - 1));
         checkOutput("in_ch", int'(in_ch), r % IN);
         checkOutput("k_x", int'(k_x), (r / IN) % kk);
         checkOutput("k_y", int'(k_y), r / (IN * kk));
         checkOutput("output_valid", int'(output_valid), int'(m_ov));
         checkOutput("output_x", int'(output_x), m_ox);
         checkOutput("output_y", int'(output_y), m_oy);
         checkOutput("output_ch", int'(output_ch), m_och);

         if (output_valid) begin
            if (layer_ov == 0) begin
               first_ov_xfer = layer_xfer;
               first_ov_cyc = cyc_count;
            end
            layer_ov++;
            last_ox = int'(output_x);
            last_oy = int'(output_y);
            last_och = int'(output_ch);
         end
         if (mac_valid) begin
            if (layer_xfer == 0) first_xfer_cyc = cyc_count;
            layer_xfer++;
         end
         if (int'(k_x) > kmax_seen) kmax_seen = int'(k_x);
         if (int'(k_y) > kmax_seen) kmax_seen = int'(k_y);

         m_ov = xfer && (r == B - 1);
         if (m_ov) begin
            m_och = o % OUT;
            m_ox = (o / OUT) % ow;
            m_oy = o / (OUT * ow);
         end
         if (m_flush) begin
            m_flush = 0;
            n = 0;
         end else if (m_run) begin
            if (xfer) n++;
            if (n == T) begin
               m_run = 0;
               m_flush = 1;
            end
         end else if (start) begin
            m_run = 1;
            m_km = conv_kernel_mode;
            m_sm = conv_stride_mode;
            n = 0;
            layer_ov = 0;
            layer_xfer = 0;
            first_ov_xfer = -1;
            first_ov_cyc = -1;
            first_xfer_cyc = -1;
            last_ox = -1;
            last_oy = -1;
            last_och = -1;
            kmax_seen = 0;
         end
      end
   end

   // Runs one layer; gap adds random valid gaps plus a 5-cycle b_valid hole, disturb pokes
   // start and the mode inputs mid-layer, rstAt>0 aborts the layer with reset after that many beats
   task automatic applyStimulus(input bit km, input bit sm, input bit gap, input bit disturb,
                                input int rstAt);
      int cyc;
      int capKx;
      int capKy;
      int capIch;
      int savedOv;
      @(posedge clk);
      #1;
      conv_kernel_mode = km;
      conv_stride_mode = sm;
      a_valid = 1'b1;
      b_valid = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      capKx = 0;
      capKy = 0;
      capIch = 0;
      while (running && cyc < BUDGET) begin
         if (rstAt > 0 && layer_xfer >= rstAt) begin
            checkOutput("abort_ov_before_reset", layer_ov, 5);
            arst_n_in = 1'b0;
            #1;
            checkOutput("abort_running", int'(running), 0);
            checkOutput("abort_a_ready", int'(a_ready), 0);
            checkOutput("abort_mac_valid", int'(mac_valid), 0);
            checkOutput("abort_output_valid", int'(output_valid), 0);
            checkOutput("abort_k_x", int'(k_x), 0);
            savedOv = layer_ov;
            repeat (2) @(posedge clk);
            #1;
            arst_n_in = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            checkOutput("abort_idle_running", int'(running), 0);
            checkOutput("abort_no_more_ov", layer_ov, savedOv);
            return;
         end
         if (gap) begin
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
            if (cyc >= 20 && cyc <= 24) begin
               a_valid = 1'b1;
               b_valid = 1'b0;
               if (cyc == 20) begin
                  capKx = int'(k_x);
                  capKy = int'(k_y);
                  capIch = int'(in_ch);
               end else begin
                  #1;
                  checkOutput("stall_a_ready", int'(a_ready), 0);
                  checkOutput("stall_b_ready", int'(b_ready), 1);
                  checkOutput("stall_mac_valid", int'(mac_valid), 0);
                  checkOutput("stall_k_x", int'(k_x), capKx);
                  checkOutput("stall_k_y", int'(k_y), capKy);
                  checkOutput("stall_in_ch", int'(in_ch), capIch);
               end
            end
         end
         if (disturb) begin
            start = ((cyc % 7) == 3);
            conv_kernel_mode = cyc[0];
            conv_stride_mode = cyc[1];
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
      if (cyc >= BUDGET) checkOutput("layer_timeout", cyc, -1);
   endtask

   initial begin
      arst_n_in = 1'b0;
      start = 1'b0;
      conv_kernel_mode = 1'b0;
      conv_stride_mode = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      #2;
      checkOutput("init_running", int'(running), 0);
      checkOutput("init_output_valid", int'(output_valid), 0);
      checkOutput("init_a_ready", int'(a_ready), 0);
      repeat (2) @(posedge clk);
      #1;
      arst_n_in = 1'b1;

      $display("[TB] layer K=3 S=1");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
      checkOutput("k3s1_outputs", layer_ov, 72);
      checkOutput("k3s1_transfers", layer_xfer, 1296);
      checkOutput("k3s1_first_after_xfers", first_ov_xfer, 18);
      checkOutput("k3s1_first_latency", first_ov_cyc - first_xfer_cyc, 18);
      checkOutput("k3s1_last_x", last_ox, 5);
      checkOutput("k3s1_last_y", last_oy, 5);
      checkOutput("k3s1_last_ch", last_och, 1);
      checkOutput("k3s1_kmax", kmax_seen, 2);

      $display("[TB] layer K=3 S=2");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
      checkOutput("k3s2_outputs", layer_ov, 18);
      checkOutput("k3s2_transfers", layer_xfer, 324);
      checkOutput("k3s2_last_x", last_ox, 2);
      checkOutput("k3s2_last_y", last_oy, 2);
      checkOutput("k3s2_last_ch", last_och, 1);

      $display("[TB] layer K=1 S=1");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
      checkOutput("k1s1_outputs", layer_ov, 128);
      checkOutput("k1s1_transfers", layer_xfer, 256);
      checkOutput("k1s1_kmax", kmax_seen, 0);
      checkOutput("k1s1_last_x", last_ox, 7);
      checkOutput("k1s1_last_y", last_oy, 7);

      $display("[TB] layer K=1 S=2");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
      checkOutput("k1s2_outputs", layer_ov, 32);
      checkOutput("k1s2_last_x", last_ox, 3);
      checkOutput("k1s2_last_y", last_oy, 3);

      $display("[TB] layer K=3 S=1 with valid gaps");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0);
      checkOutput("gap_outputs", layer_ov, 72);
      checkOutput("gap_transfers", layer_xfer, 1296);
      checkOutput("gap_last_x", last_ox, 5);
      checkOutput("gap_last_y", last_oy, 5);

      $display("[TB] layer K=3 S=1 with start and mode disturbance");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0);
      checkOutput("dist_outputs", layer_ov, 72);
      checkOutput("dist_transfers", layer_xfer, 1296);
      checkOutput("dist_last_x", last_ox, 5);
      checkOutput("dist_last_y", last_oy, 5);
      checkOutput("dist_last_ch", last_och, 1);

      $display("[TB] layer aborted by reset after 100 transfers");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 100);

      $display("[TB] full layer after reset");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
      checkOutput("post_rst_outputs", layer_ov, 72);
      checkOutput("post_rst_last_x", last_ox, 5);
      checkOutput("post_rst_last_y", last_oy, 5);

      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/conv_loop_controller.md
CONV_LOOP_CONTROLLER -- requirements
Module: conv_loop_controller

Interface
REQ-001 The block SHALL have parameter FEATURE_MAP_WIDTH, default 128: input map width in pixels.
REQ-002 The block SHALL have parameter FEATURE_MAP_HEIGHT, default 128: input map height in pixels.
REQ-003 The block SHALL have parameter INPUT_NB_CHANNELS, default 2: number of input channels.
REQ-004 The block SHALL have parameter OUTPUT_NB_CHANNELS, default 16: number of output channels.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 The block SHALL have port arst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: begin one layer; sampled in IDLE only.
REQ-008 The block SHALL have port conv_kernel_mode, input, 1 bit: 0 = 3x3 kernel (K=3), 1 = 1x1 kernel (K=1).
REQ-009 The block SHALL have port conv_stride_mode, input, 1 bit: 0 = stride 1, 1 = stride 2.
REQ-010 The block SHALL have ports a_valid, b_valid, input, 1 bit each: feature beat valid and weight beat valid.
REQ-011 The block SHALL have ports a_ready, b_ready, output, 1 bit each: feature beat accepted and weight beat accepted.
REQ-012 The block SHALL have ports k_x, k_y, output, 2 bits each, and in_ch, output, $clog2(INPUT_NB_CHANNELS) bits: current inner-loop indices.
REQ-013 The block SHALL have ports mac_valid, mac_first, mac_last, output, 1 bit each: MAC enable, accumulator clear, final term of an output.
REQ-014 The block SHALL have port output_valid, output, 1 bit: one completed output.
REQ-015 The block SHALL have ports output_x, output_y, output, $clog2(FEATURE_MAP_WIDTH) and $clog2(FEATURE_MAP_HEIGHT) bits: output coordinates.
REQ-016 The block SHALL have port output_ch, output, $clog2(OUTPUT_NB_CHANNELS) bits: output channel.
REQ-017 The block SHALL have port running, output, 1 bit: a layer is in progress.

Function
REQ-018 The block SHALL implement the FSM states IDLE, RUN and FLUSH: IDLE->RUN on start; RUN->FLUSH on the final beat; FLUSH->IDLE after 1 cycle.
REQ-019 The block SHALL register conv_kernel_mode and conv_stride_mode on the start cycle, hold them for the whole layer, and ignore changes to them in RUN and FLUSH.
REQ-020 The block SHALL ignore start in RUN and FLUSH.
REQ-021 The block SHALL set the output size as OW=(FEATURE_MAP_WIDTH-K)/S+1 and OH=(FEATURE_MAP_HEIGHT-K)/S+1, with integer division and no padding.
REQ-022 The block SHALL use the loop order, outermost to innermost: out_y, out_x, out_ch, k_y, k_x, in_ch.
REQ-023 The block SHALL drive a_ready = RUN && b_valid and b_ready = RUN && a_valid, so the two streams transfer jointly.
REQ-024 The block SHALL advance exactly one inner step per cycle in which a beat transfers, i.e. RUN && a_valid && b_valid.
REQ-025 The block SHALL drive mac_valid high on every transfer cycle; mac_first and mac_last SHALL be combinational on the current indices and gated by mac_valid.
REQ-026 The block SHALL assert mac_first when k_y=k_x=in_ch=0.
REQ-027 The block SHALL assert mac_last when k_y=k_x=K-1 and in_ch=INPUT_NB_CHANNELS-1.
REQ-028 The block SHALL hold all indices unchanged on stall cycles (either valid low), with mac_valid low.
REQ-029 The block SHALL register output_valid 1 cycle after each mac_last transfer.
REQ-030 On output_valid, the block SHALL present output_x, output_y and output_ch as the output-grid indices (0..OW-1, 0..OH-1) of the output just completed.
REQ-031 The block SHALL carry each counter to the next loop on reaching its limit and wrap it to 0; out_y wrapping SHALL mark the final beat.
REQ-032 The block SHALL produce exactly OW*OH*OUTPUT_NB_CHANNELS output_valid pulses per layer, each lasting 1 cycle.
REQ-033 The block SHALL process K*K*INPUT_NB_CHANNELS beats per output.
REQ-034 The block SHALL emit the final output_valid in the FLUSH cycle.
REQ-035 The block SHALL hold running high from the cycle after start through FLUSH, and low in IDLE.
REQ-036 The block SHALL permit a new start in the cycle after FLUSH (IDLE) and begin a new layer from it.
REQ-037 The block SHALL hold coordinate outputs at their last values while output_valid is low.

Reset
REQ-038 When arst_n_in goes low, the block SHALL immediately force IDLE, all counters to 0, and all outputs to 0, including running, a_ready, b_ready, mac_* and output_valid.
REQ-039 On reset mid-layer, the block SHALL abandon the layer with no further output_valid; after release it SHALL wait in IDLE for start.

Verification
REQ-040 The bench SHALL cover: W=H=8, IN=2, OUT=2, K=3, S=1, a_valid and b_valid held high -> 72 output_valid pulses, 18 beats each, 1296 transfers total; the first output is (0,0,ch0) after 18 transfers plus 1 cycle; the last is (5,5,ch1).
REQ-041 The bench SHALL cover: same sizes, K=3, S=2 -> OW=OH=3, 18 outputs; the last is (2,2,ch1).
REQ-042 The bench SHALL cover: K=1, S=1 -> 128 outputs, 2 beats each; k_x and k_y stay 0 throughout.
REQ-043 The bench SHALL cover: random valid gaps, b_valid low for 5 cycles while a_valid is high -> a_ready low and indices frozen; the total output count matches the no-stall run.
REQ-044 The bench SHALL cover: arst_n_in pulsed low after 100 transfers -> all outputs 0 immediately and running low; a new start then runs a full layer with 72 outputs.
REQ-045 The bench SHALL cover: start pulsed again in RUN, and mode inputs toggled in RUN -> no effect on the count or coordinates.
